ins_fetch: RTL and testbench

Instruction fetch stage directly upstream of the instruction decoder. It reads one 1024-bit VLIW instruction word as 32 consecutive 32-bit beats from a synchronous instruction memory and assembles them. It presents the word to the decoder over a valid/ready handshake. On acceptance it takes the decoder's 16-bit next-address field as the next fetch address; there is no autonomous PC increment.

---
 rtl/ins_fetch.sv | 120 ++++++++++++
 tb/tb_ins_fetch.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ins_fetch.sv
// Instruction fetch stage: reads one VLIW word as a burst of narrow memory beats,
// assembles it and hands it to the decoder, which supplies the next fetch address.
module ins_fetch #(
    parameter int              INS_W    = 1024,
    parameter int              MEM_W    = 32,
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    output logic                               mem_rd_en_o,
    output logic [PC_W+$clog2(INS_W/MEM_W)-1:0] mem_addr_o,
    input  logic [MEM_W-1:0]                   mem_rdata_i,
    output logic [INS_W-1:0]                   ins_o,
    output logic [PC_W-1:0]                    ins_pc_o,
    output logic                               ins_valid_o,
    input  logic                               ins_ready_i,
    input  logic [PC_W-1:0]                    next_pc_i,
    input  logic                               halt_i,
    output logic                               stopped_o,
    output logic [31:0]                        ins_count_o
);

    localparam int BEATS = INS_W / MEM_W;
    localparam int BW    = $clog2(BEATS);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        VALID,
        STOP
    } state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [INS_W-1:0]  ins_q, ins_d;
    logic [31:0]       count_q, count_d;
    logic              capEn;
    logic [BW-1:0]     capIdx;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            beat_q  <= '0;
            ins_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            beat_q  <= beat_d;
            ins_q   <= ins_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        beat_d  = beat_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                beat_d  = '0;
                state_d = FETCH;
            end
            FETCH: begin
                if (beat_q == BW'(BEATS - 1)) begin
                    beat_d  = '0;
                    state_d = DRAIN;
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            DRAIN: begin
                state_d = VALID;
            end
            VALID: begin
                if (ins_ready_i) begin
                    count_d = count_q + 32'd1;
                    if (halt_i) begin
                        state_d = STOP;
                    end else begin
                        pc_d    = next_pc_i;
                        beat_d  = '0;
                        state_d = FETCH;
                    end
                end
            end
            STOP: begin
                state_d = STOP;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read data lags the strobe by one cycle, so each beat lands one cycle after it was
    // addressed; the final beat is captured in DRAIN.
    always_comb begin
        capEn  = ((state_q == FETCH) && (beat_q != '0)) || (state_q == DRAIN);
        capIdx = (state_q == DRAIN) ? BW'(BEATS - 1) : (beat_q - BW'(1));
        ins_d  = ins_q;
        if (capEn) begin
            ins_d[int'(capIdx) * MEM_W +: MEM_W] = mem_rdata_i;
        end
    end

    assign mem_rd_en_o = (state_q == FETCH);
    assign mem_addr_o  = (state_q == FETCH) ? {pc_q, beat_q} : '0;
    assign ins_o       = ins_q;
    assign ins_pc_o    = pc_q;
    assign ins_valid_o = (state_q == VALID);
    assign stopped_o   = (state_q == STOP);
    assign ins_count_o = count_q;

endmodule

// File: tb/tb_ins_fetch.sv
// Self-checking bench for ins_fetch: a synchronous memory model whose words are a
// function of their address, and a reference that builds expected words and timing.
module tb_ins_fetch;

    localparam int              INS_W    = 1024;
    localparam int              MEM_W    = 32;
    localparam int              PC_W     = 16;
    localparam int              BEATS    = 32;
    localparam int              BW       = 5;
    localparam int              AW       = PC_W + BW;
    localparam logic [PC_W-1:0] RESET_PC = 16'h0000;

    logic              clk = 1'b0;
    logic              rst;
    logic              mem_rd_en;
    logic [AW-1:0]     mem_addr;
    logic [MEM_W-1:0]  mem_rdata;
    logic [INS_W-1:0]  ins;
    logic [PC_W-1:0]   ins_pc;
    logic              ins_valid;
    logic              ins_ready;
    logic [PC_W-1:0]   next_pc;
    logic              halt;
    logic              stopped;
    logic [31:0]       ins_count;

    int                checks = 0;
    int                errors = 0;
    logic [31:0]       memKey = '0;
    logic [AW-1:0]     obsAddr[$];
    int                fetchCycles;
    logic [31:0]       modelCount;

    ins_fetch #(
        .INS_W    (INS_W),
        .MEM_W    (MEM_W),
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .mem_rd_en_o (mem_rd_en),
        .mem_addr_o  (mem_addr),
        .mem_rdata_i (mem_rdata),
        .ins_o       (ins),
        .ins_pc_o    (ins_pc),
        .ins_valid_o (ins_valid),
        .ins_ready_i (ins_ready),
        .next_pc_i   (next_pc),
        .halt_i      (halt),
        .stopped_o   (stopped),
        .ins_count_o (ins_count)
    );

    always #5 clk = ~clk;

    // Memory content is the word address xor a per-test key.
    function automatic logic [MEM_W-1:0] memWord(input logic [AW-1:0] a);
        return MEM_W'(a) ^ memKey;
    endfunction

    // Synchronous instruction memory: data one cycle after the strobe.
    always @(posedge clk) begin
        if (mem_rd_en === 1'b1) mem_rdata <= memWord(mem_addr);
    end

    function automatic logic [INS_W-1:0] refWord(input logic [PC_W-1:0] pc);
        logic [INS_W-1:0] w;
        w = '0;
        for (int b = 0; b < BEATS; b++) w[b*MEM_W +: MEM_W] = memWord({pc, BW'(b)});
        return w;
    endfunction

    function automatic int firstDiff(input logic [INS_W-1:0] a, input logic [INS_W-1:0] e);
        for (int b = 0; b < BEATS; b++) begin
            if (a[b*MEM_W +: MEM_W] !== e[b*MEM_W +: MEM_W]) return b;
        end
        return -1;
    endfunction

    function automatic int addrErrors(input logic [PC_W-1:0] pc);
        int n;
        n = 0;
        if (obsAddr.size() != BEATS) return BEATS;
        for (int i = 0; i < BEATS; i++) begin
            if (obsAddr[i] !== {pc, BW'(i)}) n++;
        end
        return n;
    endfunction

    task automatic resetDut();
        rst       = 1'b1;
        ins_ready = 1'b0;
        halt      = 1'b0;
        next_pc   = '0;
        repeat (3) @(negedge clk);
        rst        = 1'b0;
        modelCount = '0;
    endtask

    // Steps until the next ins_valid (bounded), logging fetch addresses. Inputs other
    // than the acceptance already set up are scrambled to show they are ignored.
    task automatic runFetch();
        fetchCycles = 0;
        obsAddr.delete();
        do begin
            @(negedge clk);
            fetchCycles++;
            if (fetchCycles == 1) begin
                ins_ready = 1'b0;
                halt      = 1'($urandom);
                next_pc   = PC_W'($urandom);
            end
            if (mem_rd_en === 1'b1) obsAddr.push_back(mem_addr);
        end while (ins_valid !== 1'b1 && fetchCycles < 60);
    endtask

    task automatic acceptNow(input logic [PC_W-1:0] pc, input logic h);
        ins_ready  = 1'b1;
        next_pc    = pc;
        halt       = h;
        modelCount = modelCount + 32'd1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ins_ready = 1'($urandom);
            halt      = 1'($urandom);
            next_pc   = PC_W'($urandom);
            @(negedge clk);
            checks++;
            if ({ins_valid, mem_rd_en, stopped, mem_addr, ins_pc, ins_count} !==
                {3'b000, AW'(0), RESET_PC, 32'd0}) begin
                errors++;
                $display("[TB] FAIL reset outputs: got %0h expected %0h",
                         {ins_valid, mem_rd_en, stopped, mem_addr, ins_pc, ins_count},
                         {3'b000, AW'(0), RESET_PC, 32'd0});
            end
            checks++;
            if (ins !== '0) begin
                errors++;
                $display("[TB] FAIL reset ins: beat %0d nonzero", firstDiff(ins, '0));
            end
        end
        rst = 1'b0;
        ins_ready = 1'b0;
        checks++;
        if ({ins_valid, mem_rd_en, mem_addr} !== {2'b00, AW'(0)}) begin
            errors++;
            $display("[TB] FAIL cycle0 idle: got %0h expected 0", {ins_valid, mem_rd_en, mem_addr});
        end
        @(negedge clk);
        checks++;
        if ({mem_rd_en, mem_addr} !== {1'b1, AW'(0)}) begin
            errors++;
            $display("[TB] FAIL cycle1 fetch: got rd_en=%0b addr=%0h expected rd_en=1 addr=0",
                     mem_rd_en, mem_addr);
        end
    endtask

    task automatic test_basic_fetch();
        memKey = '0;
        resetDut();
        runFetch();
        checks++;
        if (fetchCycles !== 34) begin
            errors++;
            $display("[TB] FAIL basic latency: got %0d expected 34", fetchCycles);
        end
        checks++;
        if ({ins[31:0], ins[1023:992], ins_pc} !== {32'd0, 32'd31, 16'h0000}) begin
            errors++;
            $display("[TB] FAIL basic word0: got lo=%0h hi=%0h pc=%0h expected lo=0 hi=1f pc=0",
                     ins[31:0], ins[1023:992], ins_pc);
        end
        checks++;
        if (addrErrors(16'h0000) != 0) begin
            errors++;
            $display("[TB] FAIL basic addr seq: got %0d bad of %0d expected 0 bad",
                     addrErrors(16'h0000), obsAddr.size());
        end
        acceptNow(16'h0001, 1'b0);
        runFetch();
        checks++;
        if ({ins_pc, ins[31:0], ins_count} !== {16'h0001, 32'd32, 32'd1}) begin
            errors++;
            $display("[TB] FAIL basic word1: got pc=%0h lo=%0h count=%0d expected pc=1 lo=20 count=1",
                     ins_pc, ins[31:0], ins_count);
        end
        checks++;
        if (ins !== refWord(16'h0001)) begin
            errors++;
            $display("[TB] FAIL basic word1 full: beat %0d got %0h expected %0h",
                     firstDiff(ins, refWord(16'h0001)), ins[firstDiff(ins, refWord(16'h0001))*MEM_W +: MEM_W],
                     memWord({16'h0001, BW'(firstDiff(ins, refWord(16'h0001)))}));
        end
    endtask

    task automatic test_backpressure();
        logic [INS_W-1:0] heldIns;
        logic [PC_W-1:0]  heldPc;
        logic [PC_W-1:0]  jumpPc;
        memKey = $urandom;
        resetDut();
        runFetch();
        heldIns = ins;
        heldPc  = ins_pc;
        for (int i = 0; i < 10; i++) begin
            ins_ready = 1'b0;
            halt      = 1'($urandom);
            next_pc   = PC_W'($urandom);
            @(negedge clk);
            checks++;
            if (ins !== heldIns || ins_pc !== heldPc ||
                {ins_valid, mem_rd_en, ins_count} !== {2'b10, 32'd0}) begin
                errors++;
                $display("[TB] FAIL stall cycle %0d: got valid=%0b rd_en=%0b count=%0d pc=%0h expected valid=1 rd_en=0 count=0 pc=%0h",
                         i, ins_valid, mem_rd_en, ins_count, ins_pc, heldPc);
            end
        end
        jumpPc = PC_W'($urandom);
        acceptNow(jumpPc, 1'b0);
        @(negedge clk);
        ins_ready = 1'b0;
        checks++;
        if ({ins_count, ins_valid, mem_rd_en, mem_addr} !== {32'd1, 2'b01, jumpPc, BW'(0)}) begin
            errors++;
            $display("[TB] FAIL stall accept: got count=%0d valid=%0b rd_en=%0b addr=%0h expected count=1 valid=0 rd_en=1 addr=%0h",
                     ins_count, ins_valid, mem_rd_en, mem_addr, {jumpPc, BW'(0)});
        end
    endtask

    task automatic test_jump_boundary();
        memKey = $urandom;
        resetDut();
        runFetch();
        acceptNow(16'h0005, 1'b0);
        runFetch();
        checks++;
        if (addrErrors(16'h0005) != 0 || obsAddr[0] !== AW'(160) || obsAddr[BEATS-1] !== AW'(191)) begin
            errors++;
            $display("[TB] FAIL jump addr: got %0d bad expected 0 (range 160..191)", addrErrors(16'h0005));
        end
        checks++;
        if (ins !== refWord(16'h0005) || ins_pc !== 16'h0005) begin
            errors++;
            $display("[TB] FAIL jump word: got pc=%0h first bad beat %0d expected pc=5 beat -1",
                     ins_pc, firstDiff(ins, refWord(16'h0005)));
        end
        acceptNow(16'hFFFF, 1'b0);
        runFetch();
        checks++;
        if (addrErrors(16'hFFFF) != 0 || obsAddr[0] !== 21'h1FFFE0 || obsAddr[BEATS-1] !== 21'h1FFFFF) begin
            errors++;
            $display("[TB] FAIL top addr: got %0d bad expected 0 (range 1fffe0..1fffff)", addrErrors(16'hFFFF));
        end
        checks++;
        if (ins !== refWord(16'hFFFF) || ins_pc !== 16'hFFFF || fetchCycles !== 34) begin
            errors++;
            $display("[TB] FAIL top word: got pc=%0h bad beat %0d cycles %0d expected pc=ffff beat -1 cycles 34",
                     ins_pc, firstDiff(ins, refWord(16'hFFFF)), fetchCycles);
        end
    endtask

    task automatic test_back_to_back();
        logic [PC_W-1:0] pc;
        int              stall;
        memKey = $urandom;
        resetDut();
        runFetch();
        for (int n = 0; n < 6; n++) begin
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
                ins_ready = 1'b0;
                halt      = 1'($urandom);
                next_pc   = PC_W'($urandom);
                @(negedge clk);
            end
            pc = ($urandom_range(0, 3) == 0) ? ins_pc : PC_W'($urandom);
            acceptNow(pc, 1'b0);
            runFetch();
            checks++;
            if (fetchCycles !== 34 || ins_pc !== pc || ins_count !== modelCount) begin
                errors++;
                $display("[TB] FAIL b2b %0d: got cycles=%0d pc=%0h count=%0d expected cycles=34 pc=%0h count=%0d",
                         n, fetchCycles, ins_pc, ins_count, pc, modelCount);
            end
            checks++;
            if (ins !== refWord(pc) || addrErrors(pc) != 0) begin
                errors++;
                $display("[TB] FAIL b2b %0d word: got bad beat %0d bad addrs %0d expected -1 and 0",
                         n, firstDiff(ins, refWord(pc)), addrErrors(pc));
            end
        end
    endtask

    task automatic test_halt();
        memKey = $urandom;
        resetDut();
        runFetch();
        acceptNow(PC_W'($urandom), 1'b1);
        @(negedge clk);
        checks++;
        if ({stopped, ins_valid, mem_rd_en, ins_count} !== {3'b100, modelCount}) begin
            errors++;
            $display("[TB] FAIL halt entry: got stopped=%0b valid=%0b rd_en=%0b count=%0d expected 1 0 0 %0d",
                     stopped, ins_valid, mem_rd_en, ins_count, modelCount);
        end
        for (int i = 0; i < 100; i++) begin
            ins_ready = 1'($urandom);
            halt      = 1'($urandom);
            next_pc   = PC_W'($urandom);
            @(negedge clk);
            checks++;
            if ({stopped, ins_valid, mem_rd_en, ins_count} !== {3'b100, modelCount}) begin
                errors++;
                $display("[TB] FAIL halt hold %0d: got stopped=%0b valid=%0b rd_en=%0b count=%0d expected 1 0 0 %0d",
                         i, stopped, ins_valid, mem_rd_en, ins_count, modelCount);
            end
        end
    endtask

    task automatic test_reset_mid_fetch();
        bit found;
        memKey = $urandom;
        resetDut();
        runFetch();
        acceptNow(16'h0007, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            ins_ready = 1'b0;
            if (mem_rd_en === 1'b1 && mem_addr === {16'h0007, BW'(10)}) found = 1'b1;
        end
        checks++;
        if (found !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset reach beat10: got not seen expected seen");
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (ins !== '0 || {ins_valid, mem_rd_en, ins_pc, ins_count} !== {2'b00, RESET_PC, 32'd0}) begin
            errors++;
            $display("[TB] FAIL midreset state: got valid=%0b rd_en=%0b pc=%0h count=%0d nonzero beat %0d expected 0 0 %0h 0 -1",
                     ins_valid, mem_rd_en, ins_pc, ins_count, firstDiff(ins, '0), RESET_PC);
        end
        rst        = 1'b0;
        modelCount = '0;
        runFetch();
        checks++;
        if (fetchCycles !== 34 || ins_pc !== RESET_PC || ins !== refWord(RESET_PC)) begin
            errors++;
            $display("[TB] FAIL midreset refetch: got cycles=%0d pc=%0h bad beat %0d expected 34 %0h -1",
                     fetchCycles, ins_pc, firstDiff(ins, refWord(RESET_PC)), RESET_PC);
        end
    endtask

    initial begin
        rst       = 1'b1;
        ins_ready = 1'b0;
        halt      = 1'b0;
        next_pc   = '0;
        @(negedge clk);
        test_reset();
        test_basic_fetch();
        test_backpressure();
        test_jump_boundary();
        test_back_to_back();
        test_halt();
        test_reset_mid_fetch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
